orb_chan_collector: RTL and testbench
=====================================

# orb_chan_collector

Parametrised N-channel collector between the UART receivers and the orbit-frame packer. Each channel has its own byte FIFO. Received bytes are grouped into fixed-length packets, and a round-robin arbiter serialises the packets into 12-bit orbit words with write addresses for the ping-pong orbit RAM. It replaces the fixed five-channel `commutAdr`/`commRdAdr` pair and adds three features: timeout flush of partial packets with padding, a sticky per-channel overflow flag, and page latching against the frame switch.

## Interface
- `CH`, 5: number of receive channels (1..8)
- `PKT_BYTES`, 4: bytes per packet (2..16)
- `FIFO_AW`, 5: per-channel FIFO address width; depth = 2^FIFO_AW bytes
- `ADDR_W`, 11: orbit RAM address width
- `TIMEOUT`, 800: idle clocks after the last byte of a partial packet before a flush

- `clk`  in  1  system clock (clk80MHz domain)
- `rst`  in  1  synchronous, active-high reset
- `iValid`  in  CH  per-channel byte strobe, one-cycle pulse
- `iData`  in  8*CH  per-channel bytes; channel c uses bits [8c+7:8c]
- `iBase`  in  ADDR_W  slot base address, sampled at grant
- `iSW`  in  1  ping-pong frame switch, sampled at grant
- `oWE`  out  1  orbit word write strobe
- `oWrAddr`  out  ADDR_W  write address
- `oWord`  out  12  orbit word, formatted as {byte[7:0], 3'b000, pad}
- `oPage`  out  1  value of iSW latched for the current packet
- `oBusy`  out  1  high from grant until the last word is written
- `oOvf`  out  CH  sticky per-channel overflow flag

## Operation
- **Per-channel push.**
  - When `iValid[c]` is high, `iData` for channel c is written into FIFO c and `pcnt[c]` (bytes in the current packet) increments.
  - When `pcnt[c]` reaches `PKT_BYTES`, it wraps to 0 and `rdy[c]` (count of complete packets) increments.
- **Overflow.** A push into a full FIFO is dropped and sets `oOvf[c]`. The flag stays set until `rst`. A dropped byte does not count toward `pcnt`.
- **Timeout.**
  - Each channel has an idle counter. It is reloaded on every push and counts only while `pcnt[c] != 0`.
  - When the counter reaches `TIMEOUT`, `flush[c]` is set.
  - `flush[c]` is cleared when a push completes the packet, or when the channel is granted.
- **Request.** A channel requests when `rdy[c] != 0` or `flush[c]` is set.
- **Arbitration.** Round-robin. The search starts at the channel after the last granted one; after `rst` it starts at channel 0.
- **State machine.**
  - IDLE -> GRANT when any channel requests.
  - GRANT (one cycle):
    - latch the channel number, `iBase`, and `iSW` into `oPage`;
    - latch the real byte count: `PKT_BYTES` if `rdy != 0`, otherwise `pcnt`;
    - for a flushed partial packet, clear `pcnt` (same cycle).
  - GRANT -> STREAM.
  - STREAM lasts exactly `PKT_BYTES` cycles. Index i = 0..PKT_BYTES-1.
    - i below the latched count: pop the FIFO; `oWord = {byte, 3'b000, 1'b0}`.
    - Otherwise: `oWord = 12'hFF1` (pad byte 0xFF, pad bit = 1).
    - `oWrAddr = base + chan*PKT_BYTES + i`, truncated to `ADDR_W` (wraps modulo 2^ADDR_W).
  - At the end of a full packet, `rdy` decrements.
  - STREAM -> IDLE after the last word.
- **Concurrency.**
  - Bytes arriving during GRANT/STREAM for the granted channel belong to the next packet.
  - A push and a pop on the same FIFO in the same cycle are both honoured; the occupancy count stays the same.
- **Frame switch.** A change of `iSW` during STREAM has no effect on `oPage` until the next GRANT.
- **Complete beats flush.** When a channel has both complete packets and `flush` set, complete packets are served first. The flush is served after them, only if `pcnt` is still non-zero.

## Timing
- **Reset values** (one cycle after `rst` is sampled high): `oWE`=0, `oWrAddr`=0, `oWord`=0, `oPage`=0, `oBusy`=0, `oOvf`=0. All FIFOs, counters and flags are cleared and the FSM is in IDLE.
- **Latency.** If the strobe completing a packet is in cycle N on an idle block, the first `oWE` is in cycle N+3. The remaining words follow on consecutive cycles, one per clock. All outputs are registered.
- **Back-to-back packets.** A gap of at least 1 IDLE cycle and 1 GRANT cycle separates packets, so throughput is at most `PKT_BYTES` words per `PKT_BYTES`+2 cycles.
- **Flush timing.** If the last partial push is in cycle N, `flush` is set in cycle N+`TIMEOUT`.
- **`oBusy`.** High from the GRANT cycle to the last STREAM cycle inclusive.
- **Reset mid-operation.** Reset during STREAM aborts the packet. `oWE` is 0 in the next cycle and no further words are written.

## Test plan
- **Single packet.** Ch2 receives 0x11,0x22,0x33,0x44 with `iBase`=100, `iSW`=1 -> 4 consecutive `oWE`. Addresses 108..111, words 0x110,0x220,0x330,0x440, `oPage`=1. First `oWE` 3 cycles after the 4th strobe.
- **Round-robin.** Ch0, ch1 and ch4 complete packets in the same cycle -> served in order 0,1,4. Ch0 then completes again while ch1 is streaming -> served after ch4.
- **Timeout flush.** Ch3 receives 0xA5 only, then stays idle for 800 cycles -> words 0xA50,0xFF1,0xFF1,0xFF1 at base+12..15. A byte arriving after the grant starts a new packet.
- **Overflow.** FIFO_AW=2; 5 bytes pushed to ch1 while ch0 streams continuously -> `oOvf[1]`=1. The 5th byte is absent from the output, and the flag persists after drain.
- **Switch and reset.** Toggle `iSW` mid-STREAM -> `oPage` unchanged until the next packet. Assert `rst` at STREAM word 2 -> `oWE`=0 next cycle, `oOvf`=0, and no further writes.

Source files
------------

// File: rtl/orb_chan_collector.sv
// orb_chan_collector
//   N-channel byte collector feeding the orbit-frame packer. Each channel
//   owns a byte FIFO plus packet bookkeeping (orb_chan_lane). A round-robin
//   arbiter picks a channel with a complete packet (or a timed-out partial
//   one) and streams PKT_BYTES 12-bit orbit words with their RAM addresses.
//
//   clk      system clock
//   rst      synchronous active-high reset
//   iValid   per-channel byte strobe
//   iData    per-channel bytes, channel c on [8c+7:8c]
//   iBase    slot base address, sampled in GRANT
//   iSW      ping-pong frame switch, sampled in GRANT
//   oWE      orbit word write strobe
//   oWrAddr  write address = base + chan*PKT_BYTES + i (mod 2^ADDR_W)
//   oWord    {byte, 3'b000, pad}; pad word is 12'hFF1
//   oPage    iSW latched for the current packet
//   oBusy    high from GRANT through the last STREAM cycle
//   oOvf     sticky per-channel overflow flags

// One receive channel: byte FIFO, packet counters, idle timer, flags.
module orb_chan_lane #(
    parameter int PKT_BYTES = 4,
    parameter int FIFO_AW   = 5,
    parameter int TIMEOUT   = 800,
    parameter int PW        = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic [7:0]    i_data,
    input  logic          i_pop,
    input  logic          i_grant,
    output logic [7:0]    o_head,
    output logic [PW-1:0] o_pcnt,
    output logic          o_rdy,
    output logic          o_flush,
    output logic          o_ovf
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = $clog2(TIMEOUT + 1);

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wp, r_rp;
    logic [FIFO_AW:0]   r_cnt, r_rdy;
    logic [PW-1:0]      r_pcnt;
    logic [TW-1:0]      r_tmr;
    logic               r_flush, r_ovf;

    logic          w_full, w_push, w_rdy_nz, w_grant_full, w_grant_part, w_done, w_tmo;
    logic [PW-1:0] w_pc_base;

    assign w_full       = (r_cnt == (FIFO_AW+1)'(DEPTH));
    assign w_push       = i_valid & ~w_full;
    assign w_rdy_nz     = (r_rdy != '0);
    // A grant serves a complete packet if one exists, otherwise the flushed partial.
    assign w_grant_full = i_grant & w_rdy_nz;
    assign w_grant_part = i_grant & ~w_rdy_nz;
    // The partial packet handed out at grant is gone; a same-cycle byte starts afresh.
    assign w_pc_base    = w_grant_part ? '0 : r_pcnt;
    assign w_done       = w_push && (w_pc_base == PW'(PKT_BYTES - 1));
    assign w_tmo        = !w_push && (r_pcnt != '0) && !r_flush && (r_tmr == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_rdy   <= '0;
            r_pcnt  <= '0;
            r_tmr   <= '0;
            r_flush <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (i_pop)  r_rp <= r_rp + 1'b1;
            case ({w_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if (i_valid && w_full) r_ovf <= 1'b1;
            if (w_push) r_pcnt <= w_done ? '0 : w_pc_base + 1'b1;
            else        r_pcnt <= w_pc_base;
            case ({w_done, w_grant_full})
                2'b10:   r_rdy <= r_rdy + 1'b1;
                2'b01:   r_rdy <= r_rdy - 1'b1;
                default: r_rdy <= r_rdy;
            endcase
            if (w_done || w_grant_part) r_flush <= 1'b0;
            else if (w_tmo)             r_flush <= 1'b1;
            // Timer holds the number of cycles since the last push (push cycle = 1).
            if (w_push)                            r_tmr <= TW'(1);
            else if (r_pcnt != '0 && !r_flush)     r_tmr <= r_tmr + 1'b1;
        end
    end

    assign o_head  = r_mem[r_rp];
    assign o_pcnt  = r_pcnt;
    assign o_rdy   = w_rdy_nz;
    assign o_flush = r_flush;
    assign o_ovf   = r_ovf;
endmodule

module orb_chan_collector #(
    parameter int CH        = 5,
    parameter int PKT_BYTES = 4,
    parameter int FIFO_AW   = 5,
    parameter int ADDR_W    = 11,
    parameter int TIMEOUT   = 800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH-1:0]     iValid,
    input  logic [8*CH-1:0]   iData,
    input  logic [ADDR_W-1:0] iBase,
    input  logic              iSW,
    output logic              oWE,
    output logic [ADDR_W-1:0] oWrAddr,
    output logic [11:0]       oWord,
    output logic              oPage,
    output logic              oBusy,
    output logic [CH-1:0]     oOvf
);
    localparam int PW = $clog2(PKT_BYTES + 1);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_STREAM} state_t;

    state_t            r_state, w_next;
    logic [CW-1:0]     r_chan, r_ptr, w_win;
    logic [ADDR_W-1:0] r_base, w_base_sel, w_addr;
    logic [PW-1:0]     r_cnt, r_idx, w_cnt_now, w_idx;
    logic              w_any, w_load, w_real;
    logic [CW:0]       w_j;

    logic [CH-1:0]          w_rdy, w_flush, w_req, w_pop, w_grant, w_ovf;
    logic [CH-1:0][7:0]     w_head;
    logic [CH-1:0][PW-1:0]  w_pcnt;

    for (genvar c = 0; c < CH; c++) begin : g_lane
        orb_chan_lane #(
            .PKT_BYTES (PKT_BYTES),
            .FIFO_AW   (FIFO_AW),
            .TIMEOUT   (TIMEOUT),
            .PW        (PW)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_valid (iValid[c]),
            .i_data  (iData[8*c +: 8]),
            .i_pop   (w_pop[c]),
            .i_grant (w_grant[c]),
            .o_head  (w_head[c]),
            .o_pcnt  (w_pcnt[c]),
            .o_rdy   (w_rdy[c]),
            .o_flush (w_flush[c]),
            .o_ovf   (w_ovf[c])
        );
    end

    assign w_req = w_rdy | w_flush;
    assign oOvf  = w_ovf;

    // Round-robin: first requester at or after r_ptr, wrapping.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_j   = '0;
        for (int k = 0; k < CH; k++) begin
            w_j = {1'b0, r_ptr} + (CW+1)'(k);
            if (w_j >= (CW+1)'(CH)) w_j = w_j - (CW+1)'(CH);
            if (!w_any && w_req[w_j[CW-1:0]]) begin
                w_any = 1'b1;
                w_win = w_j[CW-1:0];
            end
        end
    end

    // Word i is prepared on the edge that makes it visible: word 0 leaves
    // GRANT, words 1..PKT_BYTES-1 leave STREAM cycles with r_idx = i.
    always_comb begin
        w_grant    = '0;
        w_cnt_now  = r_cnt;
        w_idx      = r_idx;
        w_base_sel = r_base;
        if (r_state == S_GRANT) begin
            w_grant    = CH'(1) << r_chan;
            w_cnt_now  = w_rdy[r_chan] ? PW'(PKT_BYTES) : w_pcnt[r_chan];
            w_idx      = '0;
            w_base_sel = iBase;
        end
        w_load = (r_state == S_GRANT) || (r_state == S_STREAM && r_idx != PW'(PKT_BYTES));
        w_real = w_load && (w_idx < w_cnt_now);
        w_pop  = w_real ? (CH'(1) << r_chan) : '0;
        w_addr = w_base_sel + ADDR_W'(r_chan) * ADDR_W'(PKT_BYTES) + ADDR_W'(w_idx);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_any) w_next = S_GRANT;
            S_GRANT:  w_next = S_STREAM;
            S_STREAM: if (r_idx == PW'(PKT_BYTES)) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chan  <= '0;
            r_ptr   <= '0;
            r_base  <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            oWE     <= 1'b0;
            oWrAddr <= '0;
            oWord   <= '0;
            oPage   <= 1'b0;
            oBusy   <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_any) r_chan <= w_win;
            if (r_state == S_GRANT) begin
                r_base <= iBase;
                oPage  <= iSW;
                r_cnt  <= w_cnt_now;
                r_idx  <= PW'(1);
                r_ptr  <= (r_chan == CW'(CH - 1)) ? '0 : r_chan + 1'b1;
            end else if (w_load) begin
                r_idx <= r_idx + 1'b1;
            end
            oWE <= w_load;
            if (w_load) begin
                oWrAddr <= w_addr;
                oWord   <= w_real ? {w_head[r_chan], 4'h0} : 12'hFF1;
            end
            oBusy <= (w_next != S_IDLE);
        end
    end
endmodule

// File: tb/tb_orb_chan_collector.sv
// Scoreboard bench for orb_chan_collector (CH=5, PKT_BYTES=4, FIFO_AW=2).
module tb_orb_chan_collector;
    localparam int CH = 5, PB = 4, FAW = 2, ADDR_W = 11, TMO = 800;

    logic              clk = 1'b0, rst = 1'b1;
    logic [CH-1:0]     iValid = '0;
    logic [8*CH-1:0]   iData = '0;
    logic [ADDR_W-1:0] iBase = '0;
    logic              iSW = 1'b0;
    logic              oWE, oPage, oBusy;
    logic [ADDR_W-1:0] oWrAddr;
    logic [11:0]       oWord;
    logic [CH-1:0]     oOvf;

    orb_chan_collector #(.CH(CH), .PKT_BYTES(PB), .FIFO_AW(FAW), .ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .iValid(iValid), .iData(iData), .iBase(iBase), .iSW(iSW),
        .oWE(oWE), .oWrAddr(oWrAddr), .oWord(oWord), .oPage(oPage), .oBusy(oBusy), .oOvf(oOvf));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [11:0]       word;
        logic              page;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_pkt(input int c, input logic [ADDR_W-1:0] base, input logic pg,
                           input logic [31:0] b, input int n);
        for (int k = 0; k < PB; k++) begin
            exp_t x;
            x.addr = base + ADDR_W'(c * PB + k);
            x.word = (k < n) ? {b[8*k +: 8], 4'h0} : 12'hFF1;
            x.page = pg;
            sb.push_back(x);
        end
    endtask

    task automatic push1(input int c, input logic [7:0] d);
        iValid = '0;
        iValid[c] = 1'b1;
        iData[8*c +: 8] = d;
        tick;
        iValid = '0;
    endtask

    task automatic wait_drain(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (sb.size() == 0 && !oBusy && !oWE) break;
            tick;
        end
        chk("drain", 32'(i < budget), 1);
    endtask

    task automatic wait_we(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (oWE) break;
        end
        chk("wait_we", 32'(i < budget), 1);
    endtask

    // Scoreboard: every write must match the oldest expected word.
    always @(negedge clk) begin
        if (oWE === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_we", 32'(sb.size()), 1);
            end else begin
                e = sb.pop_front();
                chk("addr", 32'(oWrAddr), 32'(e.addr));
                chk("word", 32'(oWord), 32'(e.word));
                chk("page", 32'(oPage), 32'(e.page));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, nw;
        // Reset values
        rst = 1'b1;
        repeat (2) tick;
        chk("rst_we",   32'(oWE),     0);
        chk("rst_addr", 32'(oWrAddr), 0);
        chk("rst_word", 32'(oWord),   0);
        chk("rst_page", 32'(oPage),   0);
        chk("rst_busy", 32'(oBusy),   0);
        chk("rst_ovf",  32'(oOvf),    0);
        rst = 1'b0;
        tick;

        // Single packet on ch2, with first-write latency
        iBase = 11'd100;
        iSW   = 1'b1;
        exp_pkt(2, 11'd100, 1'b1, 32'h44332211, 4);
        push1(2, 8'h11);
        push1(2, 8'h22);
        push1(2, 8'h33);
        iValid[2] = 1'b1;
        iData[23:16] = 8'h44;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            tick;
            iValid = '0;
            @(negedge clk);
            if (oWE) begin
                lat = k;
                break;
            end
        end
        chk("latency", 32'(lat), 3);
        wait_drain(50);

        // Round-robin after reset: 0,1,4 then ch0 again after ch4
        rst = 1'b1;
        tick;
        rst = 1'b0;
        iBase = '0;
        iSW   = 1'b0;
        exp_pkt(0, 11'd0, 1'b0, 32'h04030201, 4);
        exp_pkt(1, 11'd0, 1'b0, 32'h14131211, 4);
        exp_pkt(4, 11'd0, 1'b0, 32'h44434241, 4);
        exp_pkt(0, 11'd0, 1'b0, 32'h08070605, 4);
        for (int k = 0; k < 4; k++) begin
            iValid = 5'b10011;
            iData[7:0]   = 8'(8'h01 + k);
            iData[15:8]  = 8'(8'h11 + k);
            iData[39:32] = 8'(8'h41 + k);
            tick;
        end
        iValid = '0;
        repeat (8) tick;
        for (int k = 0; k < 4; k++) push1(0, 8'(8'h05 + k));
        wait_drain(100);

        // Timeout flush on ch3, plus a byte arriving in the GRANT cycle
        iBase = 11'd200;
        exp_pkt(3, 11'd200, 1'b0, 32'h000000A5, 1);
        iValid[3] = 1'b1;
        iData[31:24] = 8'hA5;
        for (int k = 1; k <= TMO; k++) begin
            tick;
            iValid = '0;
        end
        chk("flush_not_early", 32'(oBusy), 0);
        tick;
        chk("flush_grant", 32'(oBusy), 1);
        iValid[3] = 1'b1;
        iData[31:24] = 8'h5A;
        tick;
        iValid = '0;
        wait_drain(50);
        exp_pkt(3, 11'd200, 1'b0, 32'h0302015A, 4);
        push1(3, 8'h01);
        push1(3, 8'h02);
        push1(3, 8'h03);
        wait_drain(50);

        // Overflow on ch1 while ch0 streams
        iBase = 11'd50;
        exp_pkt(0, 11'd50, 1'b0, 32'h34333231, 4);
        exp_pkt(1, 11'd50, 1'b0, 32'h24232221, 4);
        for (int k = 0; k < 4; k++) push1(0, 8'(8'h31 + k));
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (oBusy) break;
        end
        tick;
        for (int k = 0; k < 5; k++) push1(1, 8'(8'h21 + k));
        wait_drain(100);
        chk("ovf_sticky", 32'(oOvf), 32'h2);

        // Frame switch mid-STREAM, address wrap past 2^ADDR_W
        iBase = 11'd2045;
        iSW   = 1'b0;
        exp_pkt(2, 11'd2045, 1'b0, 32'hD4D3D2D1, 4);
        for (int k = 0; k < 4; k++) push1(2, 8'(8'hD1 + k));
        wait_we(20);
        tick;
        iSW = 1'b1;
        @(negedge clk);
        chk("page_hold", 32'(oPage), 0);
        wait_drain(50);
        exp_pkt(2, 11'd2045, 1'b1, 32'hE4E3E2E1, 4);
        for (int k = 0; k < 4; k++) push1(2, 8'(8'hE1 + k));
        wait_drain(50);

        // Reset during STREAM word 2
        iBase = '0;
        exp_pkt(4, 11'd0, 1'b1, 32'hC4C3C2C1, 4);
        for (int k = 0; k < 4; k++) push1(4, 8'(8'hC1 + k));
        wait_we(20);
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_we",   32'(oWE),   0);
        chk("abort_busy", 32'(oBusy), 0);
        chk("abort_ovf",  32'(oOvf),  0);
        sb.delete();
        nw = 0;
        repeat (30) begin
            tick;
            if (oWE) nw++;
        end
        chk("no_write_after_rst", 32'(nw), 0);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
